ts_ep3_arbiter: RTL and testbench
=================================

TS_EP3_ARBITER -- requirements
Module: ts_ep3_arbiter

Interface
REQ-001 Parameter PKT_LEN, 188, TS packet length in bytes.
REQ-002 Parameter FLUSH_CYC, 4096, idle cycles before a partial buffer is force-committed.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 sel_en  in  2  source enable mask; bit0=src0 (ATSC), bit1=src1 (DVB).
REQ-006 cfg_commit_len  in  11  maximum bytes per EP3 commit; valid range PKT_LEN..1024.
REQ-007 srcN_data  in  8  byte from source N (N=0,1).
REQ-008 srcN_sop  in  1  byte is first of a TS packet.
REQ-009 srcN_valid  in  1  byte valid.
REQ-010 srcN_ready  out  1  byte accepted when valid&&ready.
REQ-011 ep3_buf_in_addr  out  11  EP3 buffer write address.
REQ-012 ep3_buf_in_data  out  8  EP3 buffer write data.
REQ-013 ep3_buf_in_wren  out  1  EP3 write strobe.
REQ-014 ep3_buf_in_ready  in  1  EP3 buffer free for filling.
REQ-015 ep3_buf_in_commit  out  1  one-cycle commit pulse.
REQ-016 ep3_buf_in_commit_len  out  11  bytes committed; stable from commit until ack.
REQ-017 ep3_buf_in_commit_ack  in  1  EP3 accepted commit.
REQ-018 active_src  out  1  source owning the current packet.
REQ-019 drop_cnt  out  16  saturating count of bytes discarded while hunting sop.

Function
REQ-020 States SHALL be WAIT_RDY, ARB, XFER, COMMIT, WAIT_ACK.
REQ-021 WAIT_RDY: srcN_ready=0; go ARB when ep3_buf_in_ready=1.
REQ-022 ARB: round-robin between enabled sources with valid&&sop; priority starts at src0 after reset, moves to the other source after each granted packet; grant -> XFER same cycle, first byte accepted in that cycle.
REQ-023 ARB: an enabled source presenting valid without sop SHALL get ready=1 and its byte dropped, drop_cnt+1 (saturate at 16'hFFFF); a disabled source's ready SHALL be 0.
REQ-024 XFER: only active_src has ready=1; accepts exactly PKT_LEN bytes; sop inside a packet is ignored (data written as-is).
REQ-025 Each accepted byte SHALL appear on ep3_buf_in_data with wren=1 and addr=fill one cycle after acceptance; fill then increments.
REQ-026 After the PKT_LEN-th byte: if fill+PKT_LEN > cfg_commit_len -> COMMIT, else -> ARB.
REQ-027 COMMIT: commit=1 for exactly one cycle, commit_len=fill, issued the cycle after the last wren; then WAIT_ACK.
REQ-028 WAIT_ACK: all srcN_ready=0; on commit_ack fill<=0, -> WAIT_RDY; ack outside WAIT_ACK ignored.
REQ-029 Flush: in ARB with fill>0 and no grant for FLUSH_CYC consecutive cycles -> COMMIT with partial length; idle counter clears on any grant.
REQ-030 sel_en change SHALL take effect only in ARB; a packet in XFER always completes even if its enable drops.
REQ-031 fill, commit_len arithmetic 11-bit unsigned; fill never exceeds cfg_commit_len.
REQ-032 cfg_commit_len sampled on entry to ARB only.

Reset
REQ-033 reset_n=0 at any edge, including mid-packet or WAIT_ACK: state WAIT_RDY, fill=0, addr=0, wren=0, commit=0, commit_len=0, srcN_ready=0, active_src=0, drop_cnt=0, RR priority src0; partial packet discarded, no commit issued.

Verification
REQ-034 cfg_commit_len=1020, src0 only, 5 packets of 0x47+0xAA*187 -> 940 wren at addr 0..939, one commit with len=940 one cycle after last wren.
REQ-035 Both sources valid continuously with sop -> packet grants alternate src0,src1,src0...; active_src toggles per packet.
REQ-036 src1 sends 10 bytes without sop, then a packet -> drop_cnt=10, packet written at addr 0.
REQ-037 One packet then silence for FLUSH_CYC cycles -> commit len=188; ack held off 50 cycles -> srcN_ready=0 throughout, ack returns state to WAIT_RDY with fill=0.
REQ-038 reset_n low at byte 100 of a packet -> all outputs at reset values next cycle; after release and ep3_buf_in_ready, next packet starts at addr 0.
REQ-039 ep3_buf_in_ready=0 after reset -> no srcN_ready, no wren, until ready asserts.

Source files
------------

// File: rtl/ts_ep3_arbiter.sv
// rtl/ts_ep3_arbiter.sv - two-source TS packet arbiter filling an EP3 commit buffer
module ts_ep3_arbiter #(
  parameter int PKT_LEN   = 188,
  parameter int FLUSH_CYC = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  sel_en,
  input  logic [10:0] cfg_commit_len,
  input  logic [7:0]  src0_data,
  input  logic        src0_sop,
  input  logic        src0_valid,
  output logic        src0_ready,
  input  logic [7:0]  src1_data,
  input  logic        src1_sop,
  input  logic        src1_valid,
  output logic        src1_ready,
  output logic [10:0] ep3_buf_in_addr,
  output logic [7:0]  ep3_buf_in_data,
  output logic        ep3_buf_in_wren,
  input  logic        ep3_buf_in_ready,
  output logic        ep3_buf_in_commit,
  output logic [10:0] ep3_buf_in_commit_len,
  input  logic        ep3_buf_in_commit_ack,
  output logic        active_src,
  output logic [15:0] drop_cnt
);

  localparam int CNT_W  = $clog2(PKT_LEN + 1);
  localparam int IDLE_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic [2:0] {WAIT_RDY, ARB, XFER, COMMIT, WAIT_ACK} state_t;

  state_t              state_q, state_d;
  logic [10:0]         fill_q, fill_d;
  logic [10:0]         cfg_q, cfg_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic                active_q, active_d;
  logic                prio_q, prio_d;
  logic [15:0]         drop_q, drop_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [10:0]         clen_q, clen_d;
  logic                commit_q, commit_d;
  logic                wren_q, wren_d;
  logic [10:0]         addr_q, addr_d;
  logic [7:0]          data_q, data_d;

  logic        rdy0, rdy1, cand0, cand1, grant, gnt_src, acc;
  logic [7:0]  acc_data;
  logic [10:0] fill_inc;
  logic [1:0]  drop_n;
  logic [16:0] drop_sum;

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    cfg_d      = cfg_q;
    byte_cnt_d = byte_cnt_q;
    active_d   = active_q;
    prio_d     = prio_q;
    drop_d     = drop_q;
    idle_d     = idle_q;
    clen_d     = clen_q;
    commit_d   = 1'b0;
    wren_d     = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    rdy0       = 1'b0;
    rdy1       = 1'b0;
    acc        = 1'b0;
    acc_data   = 8'h00;
    drop_n     = 2'd0;
    drop_sum   = 17'd0;
    fill_inc   = fill_q + 11'd1;
    cand0      = sel_en[0] & src0_valid & src0_sop;
    cand1      = sel_en[1] & src1_valid & src1_sop;
    grant      = cand0 | cand1;
    gnt_src    = (cand0 & cand1) ? prio_q : cand1;

    case (state_q)
      WAIT_RDY: begin
        if (ep3_buf_in_ready) begin
          state_d = ARB;
          cfg_d   = cfg_commit_len;
        end
      end
      ARB: begin
        // Non-sop bytes are swallowed while hunting; a losing sop holder waits.
        rdy0     = sel_en[0] & src0_valid & (~src0_sop | (grant & ~gnt_src));
        rdy1     = sel_en[1] & src1_valid & (~src1_sop | (grant & gnt_src));
        drop_n   = {1'b0, rdy0 & ~src0_sop} + {1'b0, rdy1 & ~src1_sop};
        drop_sum = {1'b0, drop_q} + 17'(drop_n);
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        if (grant) begin
          acc        = 1'b1;
          acc_data   = gnt_src ? src1_data : src0_data;
          active_d   = gnt_src;
          prio_d     = ~gnt_src;
          byte_cnt_d = CNT_W'(1);
          idle_d     = '0;
          state_d    = XFER;
        end else if (fill_q != 11'd0) begin
          if (idle_q == IDLE_W'(FLUSH_CYC - 1)) begin
            idle_d  = '0;
            state_d = COMMIT;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
      end
      XFER: begin
        rdy0     = ~active_q;
        rdy1     = active_q;
        acc      = active_q ? src1_valid : src0_valid;
        acc_data = active_q ? src1_data : src0_data;
        if (acc) begin
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          if (byte_cnt_q == CNT_W'(PKT_LEN - 1)) begin
            byte_cnt_d = '0;
            if (({1'b0, fill_inc} + 12'(PKT_LEN)) > {1'b0, cfg_q}) begin
              state_d = COMMIT;
            end else begin
              state_d = ARB;
              cfg_d   = cfg_commit_len;
            end
          end
        end
      end
      COMMIT: begin
        commit_d = 1'b1;
        clen_d   = fill_q;
        state_d  = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ep3_buf_in_commit_ack) begin
          fill_d  = 11'd0;
          state_d = WAIT_RDY;
        end
      end
      default: state_d = WAIT_RDY;
    endcase

    if (acc) begin
      wren_d = 1'b1;
      addr_d = fill_q;
      data_d = acc_data;
      fill_d = fill_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= WAIT_RDY;
      fill_q     <= 11'd0;
      cfg_q      <= 11'd0;
      byte_cnt_q <= '0;
      active_q   <= 1'b0;
      prio_q     <= 1'b0;
      drop_q     <= 16'd0;
      idle_q     <= '0;
      clen_q     <= 11'd0;
      commit_q   <= 1'b0;
      wren_q     <= 1'b0;
      addr_q     <= 11'd0;
      data_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      cfg_q      <= cfg_d;
      byte_cnt_q <= byte_cnt_d;
      active_q   <= active_d;
      prio_q     <= prio_d;
      drop_q     <= drop_d;
      idle_q     <= idle_d;
      clen_q     <= clen_d;
      commit_q   <= commit_d;
      wren_q     <= wren_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  // Ready is held low while reset is asserted so no source sees a phantom handshake.
  assign src0_ready            = rdy0 & reset_n;
  assign src1_ready            = rdy1 & reset_n;
  assign ep3_buf_in_addr       = addr_q;
  assign ep3_buf_in_data       = data_q;
  assign ep3_buf_in_wren       = wren_q;
  assign ep3_buf_in_commit     = commit_q;
  assign ep3_buf_in_commit_len = clen_q;
  assign active_src            = active_q;
  assign drop_cnt              = drop_q;

endmodule

// File: tb/tb_ts_ep3_arbiter.sv
// tb/tb_ts_ep3_arbiter.sv - scoreboard bench for ts_ep3_arbiter
module tb_ts_ep3_arbiter;
  localparam int PKT_LEN   = 188;
  localparam int FLUSH_CYC = 4096;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  sel_en;
  logic [10:0] cfg_commit_len;
  logic [7:0]  src0_data, src1_data;
  logic        src0_sop, src0_valid, src0_ready;
  logic        src1_sop, src1_valid, src1_ready;
  logic [10:0] ep3_buf_in_addr;
  logic [7:0]  ep3_buf_in_data;
  logic        ep3_buf_in_wren;
  logic        ep3_buf_in_ready;
  logic        ep3_buf_in_commit;
  logic [10:0] ep3_buf_in_commit_len;
  logic        ep3_buf_in_commit_ack;
  logic        active_src;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  ts_ep3_arbiter #(.PKT_LEN(PKT_LEN), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk(clk), .reset_n(reset_n), .sel_en(sel_en), .cfg_commit_len(cfg_commit_len),
    .src0_data(src0_data), .src0_sop(src0_sop), .src0_valid(src0_valid), .src0_ready(src0_ready),
    .src1_data(src1_data), .src1_sop(src1_sop), .src1_valid(src1_valid), .src1_ready(src1_ready),
    .ep3_buf_in_addr(ep3_buf_in_addr), .ep3_buf_in_data(ep3_buf_in_data),
    .ep3_buf_in_wren(ep3_buf_in_wren), .ep3_buf_in_ready(ep3_buf_in_ready),
    .ep3_buf_in_commit(ep3_buf_in_commit), .ep3_buf_in_commit_len(ep3_buf_in_commit_len),
    .ep3_buf_in_commit_ack(ep3_buf_in_commit_ack), .active_src(active_src), .drop_cnt(drop_cnt)
  );

  int checks = 0, errors = 0;
  logic [18:0] exp_wr_q[$];
  logic [10:0] exp_commit_q[$];
  int cyc = 0, last_wren_cyc = 0, last_commit_cyc = 0, commit_seen = 0;
  logic [10:0] fill_m;
  logic        prio_m;
  logic [18:0] mon_e;
  logic [10:0] mon_c;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (ep3_buf_in_wren === 1'b1) begin
      last_wren_cyc = cyc;
      check("wren_expected", exp_wr_q.size() != 0, 1);
      if (exp_wr_q.size() != 0) begin
        mon_e = exp_wr_q.pop_front();
        check("wr_addr", ep3_buf_in_addr, mon_e[18:8]);
        check("wr_data", ep3_buf_in_data, mon_e[7:0]);
      end
    end
    if (ep3_buf_in_commit === 1'b1) begin
      commit_seen++;
      last_commit_cyc = cyc;
      check("commit_expected", exp_commit_q.size() != 0, 1);
      if (exp_commit_q.size() != 0) begin
        mon_c = exp_commit_q.pop_front();
        check("commit_len", ep3_buf_in_commit_len, mon_c);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input logic [7:0] d, input logic sop, input logic v);
    if (s == 0) begin src0_data = d; src0_sop = sop; src0_valid = v; end
    else begin src1_data = d; src1_sop = sop; src1_valid = v; end
  endtask

  function automatic logic rdy(input int s);
    return (s == 0) ? src0_ready : src1_ready;
  endfunction

  function automatic logic [7:0] pkt_byte(input int s, input int i, input logic [7:0] seed);
    if (i == 0) return 8'h47;
    if (seed == 8'h00) return 8'hAA;
    return 8'(i) ^ seed ^ ((s == 1) ? 8'h5A : 8'h00);
  endfunction

  // Entered at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_byte(input int s, input logic [7:0] d, input logic sop, input bit exp_write);
    int n = 0;
    drive(s, d, sop, 1'b1);
    #1;
    while (!rdy(s) && n < 300) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("handshake_timeout", n < 300, 1);
    if (exp_write) begin
      exp_wr_q.push_back({fill_m, d});
      fill_m++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int s, input logic [7:0] seed, input int nbytes);
    for (int i = 0; i < nbytes; i++) send_byte(s, pkt_byte(s, i, seed), i == 0, 1'b1);
  endtask

  task automatic wait_commits(input int limit);
    int n = 0;
    while (exp_commit_q.size() != 0 && n < limit) begin tick(); n++; end
    check("commit_timeout", exp_commit_q.size() == 0, 1);
  endtask

  task automatic pulse_ack();
    ep3_buf_in_commit_ack = 1'b1;
    tick();
    ep3_buf_in_commit_ack = 1'b0;
    fill_m = 11'd0;
  endtask

  initial begin
    int idx [2];
    int pkts_done, fd;
    logic chk_act, exp_act;

    reset_n = 1'b0; sel_en = 2'b00; cfg_commit_len = 11'd1020;
    src0_data = 8'h00; src0_sop = 1'b0; src0_valid = 1'b0;
    src1_data = 8'h00; src1_sop = 1'b0; src1_valid = 1'b0;
    ep3_buf_in_ready = 1'b0; ep3_buf_in_commit_ack = 1'b0;
    fill_m = 11'd0; prio_m = 1'b0;
    repeat (3) tick();

    check("rst_wren", ep3_buf_in_wren, 0);
    check("rst_addr", ep3_buf_in_addr, 0);
    check("rst_commit", ep3_buf_in_commit, 0);
    check("rst_commit_len", ep3_buf_in_commit_len, 0);
    check("rst_active", active_src, 0);
    check("rst_drop", drop_cnt, 0);

    // Buffer not ready: sources stay stalled.
    reset_n = 1'b1; sel_en = 2'b11;
    drive(0, 8'h47, 1'b1, 1'b1);
    drive(1, 8'h47, 1'b1, 1'b1);
    for (int c = 0; c < 20; c++) begin
      #1;
      check("nobuf_ready0", src0_ready, 0);
      check("nobuf_ready1", src1_ready, 0);
      tick();
    end
    drive(1, 8'h00, 1'b0, 1'b0);
    ep3_buf_in_ready = 1'b1;

    // Five 0xAA packets from src0 into a 1020-byte commit window.
    sel_en = 2'b01;
    for (int p = 0; p < 5; p++) send_pkt(0, 8'h00, PKT_LEN);
    exp_commit_q.push_back(11'd940);
    drive(0, 8'h47, 1'b1, 1'b1);
    wait_commits(20);
    check("commit_after_wren", last_commit_cyc - last_wren_cyc, 1);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("waitack_ready0", src0_ready, 0);
      tick();
    end
    drive(0, 8'h00, 1'b0, 1'b0);
    pulse_ack();

    // Round-robin with both sources streaming sop packets; stray acks ignored.
    reset_n = 1'b0; repeat (2) tick(); reset_n = 1'b1;
    fill_m = 11'd0; prio_m = 1'b0;
    sel_en = 2'b11; ep3_buf_in_commit_ack = 1'b1;
    idx[0] = 0; idx[1] = 0; pkts_done = 0; chk_act = 1'b0; exp_act = 1'b0;
    for (int c = 0; c < 2000 && pkts_done < 4; c++) begin
      if (chk_act) begin check("active_src", active_src, exp_act); chk_act = 1'b0; end
      for (int s = 0; s < 2; s++) drive(s, pkt_byte(s, idx[s], 8'h3C), idx[s] == 0, 1'b1);
      #1;
      check("single_ready", src0_ready & src1_ready, 0);
      for (int s = 0; s < 2; s++) begin
        if (rdy(s)) begin
          if (idx[s] == 0) begin
            check("grant_order", s, prio_m);
            prio_m = (s == 0);
            chk_act = 1'b1;
            exp_act = (s == 1);
          end
          exp_wr_q.push_back({fill_m, pkt_byte(s, idx[s], 8'h3C)});
          fill_m++;
          idx[s]++;
          if (idx[s] == PKT_LEN) begin idx[s] = 0; pkts_done++; end
        end
      end
      tick();
    end
    drive(0, 8'h00, 1'b0, 1'b0);
    drive(1, 8'h00, 1'b0, 1'b0);
    ep3_buf_in_commit_ack = 1'b0;
    check("rr_packets", pkts_done, 4);
    check("rr_last_active", active_src, 1);
    tick(); tick();
    check("rr_drained", exp_wr_q.size(), 0);

    // src1 junk without sop is dropped; disabled src0 never gets ready.
    reset_n = 1'b0; repeat (2) tick(); reset_n = 1'b1;
    fill_m = 11'd0; prio_m = 1'b0;
    sel_en = 2'b10;
    drive(0, 8'h47, 1'b1, 1'b1);
    for (int j = 0; j < 10; j++) send_byte(1, 8'hF0 + 8'(j), 1'b0, 1'b0);
    check("drop_cnt", drop_cnt, 10);
    #1;
    check("disabled_ready0", src0_ready, 0);
    send_pkt(1, 8'h77, PKT_LEN);
    drive(0, 8'h00, 1'b0, 1'b0);
    drive(1, 8'h00, 1'b0, 1'b0);
    check("drop_active", active_src, 1);

    // Idle flush of one packet, then a long-held ack.
    exp_commit_q.push_back(11'd188);
    wait_commits(FLUSH_CYC + 50);
    fd = last_commit_cyc - last_wren_cyc;
    check("flush_delay", (fd >= FLUSH_CYC) && (fd <= FLUSH_CYC + 2), 1);
    sel_en = 2'b11;
    drive(0, 8'h47, 1'b1, 1'b1);
    drive(1, 8'h47, 1'b1, 1'b1);
    for (int c = 0; c < 50; c++) begin
      #1;
      check("hold_ready0", src0_ready, 0);
      check("hold_ready1", src1_ready, 0);
      tick();
    end
    check("hold_commit_len", ep3_buf_in_commit_len, 188);
    drive(0, 8'h00, 1'b0, 1'b0);
    drive(1, 8'h00, 1'b0, 1'b0);
    pulse_ack();

    // Reset in the middle of a packet.
    sel_en = 2'b01;
    send_pkt(0, 8'h19, 100);
    drive(0, pkt_byte(0, 100, 8'h19), 1'b0, 1'b1);
    reset_n = 1'b0;
    #1;
    check("midrst_ready0_low", src0_ready, 0);
    tick();
    check("midrst_wren", ep3_buf_in_wren, 0);
    check("midrst_addr", ep3_buf_in_addr, 0);
    check("midrst_commit", ep3_buf_in_commit, 0);
    check("midrst_commit_len", ep3_buf_in_commit_len, 0);
    check("midrst_active", active_src, 0);
    check("midrst_drop", drop_cnt, 0);
    check("midrst_ready0", src0_ready, 0);
    drive(0, 8'h00, 1'b0, 1'b0);
    tick();
    reset_n = 1'b1; fill_m = 11'd0; prio_m = 1'b0;
    tick();
    send_pkt(0, 8'h61, PKT_LEN);
    drive(0, 8'h00, 1'b0, 1'b0);
    repeat (3) tick();

    check("final_wr_drained", exp_wr_q.size(), 0);
    check("final_commit_count", commit_seen, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
